operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 21 ++
 rtl/operand_fetch_regfile_sb.sv | 61 ++++++
 rtl/operand_fetch.sv | 86 ++++++++
 tb/tb_operand_fetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch slice: ALU opcode encoding,
// default geometry and the handshake FSM state type.
package operand_fetch_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREGS_DEF  = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_LI  = 3'b111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/operand_fetch_regfile_sb.sv
// Register file with per-register busy scoreboard and writeback forwarding
// onto both read ports; reports whether the offered instruction is hazarded.
module regfile_sb
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int RW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [RW-1:0]     rs1,
  input  logic [RW-1:0]     rs2,
  input  logic [RW-1:0]     rd,
  input  logic              use_rs,
  input  logic              set_busy,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              hazard
);

  logic [DATA_W-1:0] regs_p1 [NREGS];
  logic [NREGS-1:0]  busy_p1;
  logic [NREGS-1:0]  busy_nxt;
  logic              rs1_hit, rs2_hit, rd_hit;
  logic              rs1_blk, rs2_blk, rd_blk;

  // A writeback landing this cycle both forwards its data and lifts the hazard
  assign rs1_hit = wb_valid && (wb_rd == rs1);
  assign rs2_hit = wb_valid && (wb_rd == rs2);
  assign rd_hit  = wb_valid && (wb_rd == rd);

  assign rs1_blk = busy_p1[rs1] && !rs1_hit;
  assign rs2_blk = busy_p1[rs2] && !rs2_hit;
  assign rd_blk  = busy_p1[rd]  && !rd_hit;

  assign hazard   = rd_blk || (use_rs && (rs1_blk || rs2_blk));
  assign rs1_data = rs1_hit ? wb_data : regs_p1[rs1];
  assign rs2_data = rs2_hit ? wb_data : regs_p1[rs2];

  always_comb begin
    busy_nxt = busy_p1;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    if (set_busy) busy_nxt[rd]    = 1'b1;
  end

  // ---- p1: architectural state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_p1 <= '0;
      for (int i = 0; i < NREGS; i++) regs_p1[i] <= '0;
    end else begin
      busy_p1 <= busy_nxt;
      if (wb_valid) regs_p1[wb_rd] <= wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts an instruction when no scoreboard hazard exists,
// reads/forwards its sources and holds them for the ALU under valid/ready.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int RW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [RW-1:0]     instr_rd,
  input  logic [RW-1:0]     instr_rs1,
  input  logic [RW-1:0]     instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [2:0]        alu_op,
  output logic [RW-1:0]     rd,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  state_e            state_p1;
  logic [DATA_W-1:0] a_p1, b_p1;
  logic [2:0]        alu_op_p1;
  logic [RW-1:0]     rd_p1;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              hazard, is_li, accept;

  assign is_li       = (instr_op == OP_LI);
  assign instr_ready = ((state_p1 == ST_EMPTY) || op_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  regfile_sb #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .RW     (RW)
  ) u_regfile_sb (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .rs1      (instr_rs1),
    .rs2      (instr_rs2),
    .rd       (instr_rd),
    .use_rs   (!is_li),
    .set_busy (accept),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .hazard   (hazard)
  );

  // ---- p1: operand holding register toward the ALU ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1  <= ST_EMPTY;
      a_p1      <= '0;
      b_p1      <= '0;
      alu_op_p1 <= '0;
      rd_p1     <= '0;
    end else if (accept) begin
      state_p1  <= ST_FULL;
      a_p1      <= is_li ? '0 : rs1_data;
      b_p1      <= is_li ? instr_imm : rs2_data;
      alu_op_p1 <= instr_op;
      rd_p1     <= instr_rd;
    end else if (op_ready) begin
      state_p1  <= ST_EMPTY;
    end
  end

  assign op_valid = (state_p1 == ST_FULL);
  assign a        = a_p1;
  assign b        = b_p1;
  assign alu_op   = alu_op_p1;
  assign rd       = rd_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed plus randomized checks of operand_fetch against a cycle-level
// behavioural model of the register file, scoreboard and operand buffer.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [2:0]    instr_op = '0;
  logic [RW-1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [DW-1:0] instr_imm = '0;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [DW-1:0] a, b;
  logic [2:0]    alu_op;
  logic [RW-1:0] rd;
  logic          wb_valid = 1'b0;
  logic [RW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;

  operand_fetch #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .op_valid(op_valid), .op_ready(op_ready),
    .a(a), .b(b), .alu_op(alu_op), .rd(rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            m_full;
  logic [DW-1:0] m_a, m_b;
  logic [2:0]    m_op;
  logic [RW-1:0] m_rd;

  int   n_vec = 0, n_cmp = 0, n_err = 0;
  logic last_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit blk(input logic [RW-1:0] i, input bit wv, input logic [RW-1:0] wrd);
    return m_busy[i] && !(wv && wrd == i);
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] i, input bit wv,
                                        input logic [RW-1:0] wrd, input logic [DW-1:0] wdat);
    return (wv && wrd == i) ? wdat : m_regs[i];
  endfunction

  task automatic step(input bit rst, input bit iv, input logic [2:0] op,
                      input logic [RW-1:0] rd_i, input logic [RW-1:0] rs1_i,
                      input logic [RW-1:0] rs2_i, input logic [DW-1:0] imm,
                      input bit ordy, input bit wv, input logic [RW-1:0] wrd,
                      input logic [DW-1:0] wdat);
    bit            li, exp_rdy, acc;
    logic [DW-1:0] fa, fb;
    reset = rst; instr_valid = iv; instr_op = op; instr_rd = rd_i;
    instr_rs1 = rs1_i; instr_rs2 = rs2_i; instr_imm = imm;
    op_ready = ordy; wb_valid = wv; wb_rd = wrd; wb_data = wdat;
    #1;
    li      = (op == OP_LI);
    exp_rdy = (!m_full || ordy) && !blk(rd_i, wv, wrd) &&
              (li || (!blk(rs1_i, wv, wrd) && !blk(rs2_i, wv, wrd)));
    last_rdy = instr_ready;
    if (!rst) chk("instr_ready", {31'b0, instr_ready}, {31'b0, exp_rdy});
    fa  = li ? '0 : fwd(rs1_i, wv, wrd, wdat);
    fb  = li ? imm : fwd(rs2_i, wv, wrd, wdat);
    acc = iv && exp_rdy;
    @(posedge clk);
    n_vec++;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
      m_full = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
    end else begin
      if (wv) begin m_regs[wrd] = wdat; m_busy[wrd] = 0; end
      if (acc) m_busy[rd_i] = 1;
      if (acc) begin
        m_full = 1; m_a = fa; m_b = fb; m_op = op; m_rd = rd_i;
      end else if (ordy) begin
        m_full = 0;
      end
    end
    #1;
    chk("op_valid", {31'b0, op_valid}, {31'b0, m_full});
    chk("a", {24'b0, a}, {24'b0, m_a});
    chk("b", {24'b0, b}, {24'b0, m_b});
    chk("alu_op", {29'b0, alu_op}, {29'b0, m_op});
    chk("rd", {30'b0, rd}, {30'b0, m_rd});
  endtask

  task automatic issue(input logic [2:0] op, input logic [RW-1:0] rd_i,
                       input logic [RW-1:0] rs1_i, input logic [RW-1:0] rs2_i,
                       input logic [DW-1:0] imm, input bit ordy);
    step(0, 1, op, rd_i, rs1_i, rs2_i, imm, ordy, 0, '0, '0);
  endtask

  task automatic wb(input logic [RW-1:0] wrd, input logic [DW-1:0] wdat, input bit ordy);
    step(0, 0, OP_AND, '0, '0, '0, '0, ordy, 1, wrd, wdat);
  endtask

  initial begin
    logic [2:0] ops [7];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOT, OP_LI};
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    m_full = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;

    // Reset state
    step(1, 0, OP_AND, '0, '0, '0, '0, 0, 0, '0, '0);
    step(1, 1, OP_LI, 2'd1, '0, '0, 8'h99, 1, 1, 2'd2, 8'h42);
    chk("rst_op_valid", {31'b0, op_valid}, 32'd0);
    chk("rst_a", {24'b0, a}, 32'd0);

    // Two LIs back to back
    issue(OP_LI, 2'd1, 2'd0, 2'd0, 8'hF0, 1);
    chk("rdy_after_rst", {31'b0, last_rdy}, 32'd1);
    chk("li1_b", {24'b0, b}, 32'hF0);
    issue(OP_LI, 2'd2, 2'd0, 2'd0, 8'h3C, 1);
    chk("li2_valid", {31'b0, op_valid}, 32'd1);
    chk("li2_b", {24'b0, b}, 32'h3C);
    issue(OP_AND, 2'd3, 2'd1, 2'd1, '0, 1);
    chk("busy1_blocks", {31'b0, last_rdy}, 32'd0);
    issue(OP_AND, 2'd3, 2'd2, 2'd2, '0, 1);
    chk("busy2_blocks", {31'b0, last_rdy}, 32'd0);

    // Writebacks then AND r3,r1,r2
    wb(2'd1, 8'hF0, 1);
    wb(2'd2, 8'h3C, 1);
    issue(OP_AND, 2'd3, 2'd1, 2'd2, '0, 1);
    chk("and_a", {24'b0, a}, 32'hF0);
    chk("and_b", {24'b0, b}, 32'h3C);
    chk("and_rd", {30'b0, rd}, 32'd3);

    // RAW stall released by same-cycle forwarding
    issue(OP_LI, 2'd1, 2'd0, 2'd0, 8'h11, 1);
    issue(OP_AND, 2'd0, 2'd1, 2'd1, '0, 1);
    chk("raw_blocked", {31'b0, last_rdy}, 32'd0);
    step(0, 1, OP_AND, 2'd0, 2'd1, 2'd1, '0, 1, 1, 2'd1, 8'h55);
    chk("fwd_accept", {31'b0, last_rdy}, 32'd1);
    chk("fwd_a", {24'b0, a}, 32'h55);
    chk("fwd_b", {24'b0, b}, 32'h55);

    // Backpressure hold
    for (int i = 0; i < 5; i++) begin
      issue(OP_LI, 2'd2, 2'd0, 2'd0, 8'h77, 0);
      chk("hold_rdy", {31'b0, last_rdy}, 32'd0);
      chk("hold_a", {24'b0, a}, 32'h55);
    end
    step(0, 0, OP_AND, '0, '0, '0, '0, 1, 0, '0, '0);
    chk("drain_empty", {31'b0, op_valid}, 32'd0);

    // Reset while FULL with busy[3] outstanding
    issue(OP_LI, 2'd2, 2'd0, 2'd0, 8'h77, 1);
    chk("full_before_rst", {31'b0, op_valid}, 32'd1);
    step(1, 1, OP_LI, 2'd3, '0, '0, 8'hAA, 0, 1, 2'd3, 8'hEE);
    chk("rst_mid_valid", {31'b0, op_valid}, 32'd0);
    issue(OP_AND, 2'd0, 2'd3, 2'd3, '0, 1);
    chk("r3_unbusy", {31'b0, last_rdy}, 32'd1);
    chk("r3_zero", {24'b0, a}, 32'd0);

    // Eight independent LIs streaming with no bubble
    for (int i = 0; i < 8; i++) begin
      step(0, 1, OP_LI, RW'(i % NR), '0, '0, 8'hA0 + 8'(i), 1, 1, RW'(i % NR), 8'(i));
      chk("stream_rdy", {31'b0, last_rdy}, 32'd1);
      chk("stream_valid", {31'b0, op_valid}, 32'd1);
      chk("stream_b", {24'b0, b}, 32'hA0 + 32'(i));
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
           ops[$urandom_range(0, 6)], RW'($urandom), RW'($urandom), RW'($urandom),
           8'($urandom), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
           RW'($urandom), 8'($urandom));
    end
    step(0, 0, OP_AND, '0, '0, '0, '0, 1, 0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
